// File: rtl/glitch_pkg.sv
// glitch_pkg: shared opcodes, instruction field positions and the sequencer state type.
// Exports:
//   OP_*           2-bit opcodes carried in instr[11:10]
//   HALT_PAYLOAD   PULSE payload that ends the program instead of pulsing
//   *_POS/*_MSB/*_LSB  bit positions of the instruction fields
//   PAT_W          width of a pulse pattern
//   state_t        sequencer FSM states
//   frame_ok()     start/stop framing check of an instruction
package glitch_pkg;
    localparam logic [1:0] OP_SEND  = 2'b00;
    localparam logic [1:0] OP_PULSE = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;
    localparam logic [7:0] HALT_PAYLOAD = 8'hFF;
    localparam int OP_MSB    = 11;
    localparam int OP_LSB    = 10;
    localparam int START_POS = 9;
    localparam int PAY_MSB   = 8;
    localparam int PAY_LSB   = 1;
    localparam int STOP_POS  = 0;
    localparam int PAT_W     = 8;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_DLY_LOAD,
        S_DLY_RUN,
        S_PULSE,
        S_DONE
    } state_t;
    function automatic logic frame_ok(input logic [11:0] ir);
        return ir[START_POS] && !ir[STOP_POS];
    endfunction
endpackage

// File: rtl/glitch_sequencer_pulse_shifter.sv
// pulse_shifter: parallel-load pattern shifter, MSB first, each bit held BIT_CYCLES cycles.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_clear         synchronous abort: drops the pattern and the output bit
//   i_load          loads i_pattern; its MSB is on o_bit_out the next cycle
//   i_pattern       8-bit pattern
//   o_active        high while a pattern is being shifted out
//   o_last          high in the final cycle of the final bit
//   o_bit_out       registered pulse drive, 0 when idle
module pulse_shifter
    import glitch_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [PAT_W-1:0] i_pattern,
    output logic             o_active,
    output logic             o_last,
    output logic             o_bit_out
);
    localparam int PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [PAT_W-1:0] r_sh;
    logic [PW-1:0]    r_pre;
    logic [2:0]       r_idx;
    logic             r_active;
    logic             r_bit;
    logic             w_bit_end;

    assign w_bit_end = (r_pre == PW'(BIT_CYCLES - 1));
    assign o_last    = r_active && w_bit_end && (r_idx == 3'd7);
    assign o_active  = r_active;
    assign o_bit_out = r_bit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh     <= '0;
            r_pre    <= '0;
            r_idx    <= '0;
            r_active <= 1'b0;
            r_bit    <= 1'b0;
        end else if (i_clear) begin
            r_sh     <= '0;
            r_pre    <= '0;
            r_idx    <= '0;
            r_active <= 1'b0;
            r_bit    <= 1'b0;
        end else if (i_load) begin
            r_sh     <= i_pattern;
            r_pre    <= '0;
            r_idx    <= '0;
            r_active <= 1'b1;
            r_bit    <= i_pattern[PAT_W-1];
        end else if (r_active) begin
            if (w_bit_end) begin
                r_pre <= '0;
                if (r_idx == 3'd7) begin
                    r_active <= 1'b0;
                    r_bit    <= 1'b0;
                end else begin
                    r_idx <= r_idx + 3'd1;
                    r_sh  <= {r_sh[PAT_W-2:0], 1'b0};
                    r_bit <= r_sh[PAT_W-2];
                end
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end
endmodule

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: fetches and executes glitch program instructions from a combinational ROM.
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_start                     run request, honoured in IDLE/DONE
//   i_abort                     synchronous abort back to IDLE
//   o_instr_pt / i_instr        ROM instruction address / instruction
//   o_delay_num / i_delay_len   ROM delay-table index / delay length
//   o_tx_data, o_tx_valid, i_tx_ready  byte send handshake
//   o_glitch_out                glitch pulse drive
//   o_busy, o_done, o_err       status (err is sticky until the next start)
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int PROG_LEN   = 14,
    parameter int BIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    output logic [7:0]  o_instr_pt,
    input  logic [11:0] i_instr,
    output logic [7:0]  o_delay_num,
    input  logic [31:0] i_delay_len,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_glitch_out,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);
    state_t      r_state, w_state;
    logic [7:0]  r_instr_pt, w_instr_pt;
    logic [11:0] r_ir, w_ir;
    logic [7:0]  r_delay_num, w_delay_num;
    logic [7:0]  r_tx_data, w_tx_data;
    logic        r_tx_valid, w_tx_valid;
    logic [31:0] r_cnt, w_cnt;
    logic        r_err, w_err;
    logic        r_busy, r_done;
    logic        w_load, w_active, w_last;
    logic [1:0]  w_op;
    logic [7:0]  w_pay;

    assign w_op  = r_ir[OP_MSB:OP_LSB];
    assign w_pay = r_ir[PAY_MSB:PAY_LSB];

    pulse_shifter #(.BIT_CYCLES(BIT_CYCLES)) u_shifter (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (i_abort),
        .i_load    (w_load),
        .i_pattern (w_pay),
        .o_active  (w_active),
        .o_last    (w_last),
        .o_bit_out (o_glitch_out)
    );

    always_comb begin
        w_state     = r_state;
        w_instr_pt  = r_instr_pt;
        w_ir        = r_ir;
        w_delay_num = r_delay_num;
        w_tx_data   = r_tx_data;
        w_tx_valid  = r_tx_valid;
        w_cnt       = r_cnt;
        w_err       = r_err;
        w_load      = 1'b0;
        if (i_abort) begin
            w_state    = S_IDLE;
            w_tx_valid = 1'b0;
            w_cnt      = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        w_instr_pt = '0;
                        w_err      = 1'b0;
                        w_state    = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (r_instr_pt == 8'(PROG_LEN)) begin
                        w_state = S_DONE;
                    end else begin
                        w_ir    = i_instr;
                        w_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!frame_ok(r_ir)) begin
                        w_err   = 1'b1;
                        w_state = S_DONE;
                    end else if (w_op == OP_SEND) begin
                        w_tx_data  = w_pay;
                        w_tx_valid = 1'b1;
                        w_state    = S_SEND;
                    end else if (w_op == OP_DELAY) begin
                        w_delay_num = w_pay;
                        w_state     = S_DLY_LOAD;
                    end else if (w_op == OP_PULSE) begin
                        w_load  = (w_pay != HALT_PAYLOAD);
                        w_state = (w_pay == HALT_PAYLOAD) ? S_DONE : S_PULSE;
                    end else begin
                        // reserved opcode: flag it but keep running as a NOP
                        w_err      = (w_op == OP_RSVD) | r_err;
                        w_instr_pt = r_instr_pt + 8'd1;
                        w_state    = S_FETCH;
                    end
                end
                S_SEND: begin
                    if (i_tx_ready) begin
                        w_tx_valid = 1'b0;
                        w_instr_pt = r_instr_pt + 8'd1;
                        w_state    = S_FETCH;
                    end
                end
                S_DLY_LOAD: begin
                    w_cnt   = i_delay_len;
                    w_state = S_DLY_RUN;
                end
                S_DLY_RUN: begin
                    // a loaded length of 0 leaves after one cycle, same as 1
                    if (r_cnt <= 32'd1) begin
                        w_cnt      = '0;
                        w_instr_pt = r_instr_pt + 8'd1;
                        w_state    = S_FETCH;
                    end else begin
                        w_cnt = r_cnt - 32'd1;
                    end
                end
                S_PULSE: begin
                    if (w_last || !w_active) begin
                        w_instr_pt = r_instr_pt + 8'd1;
                        w_state    = S_FETCH;
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_instr_pt  <= '0;
            r_ir        <= '0;
            r_delay_num <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_instr_pt  <= w_instr_pt;
            r_ir        <= w_ir;
            r_delay_num <= w_delay_num;
            r_tx_data   <= w_tx_data;
            r_tx_valid  <= w_tx_valid;
            r_cnt       <= w_cnt;
            r_err       <= w_err;
            // status is registered from the next state so it lines up with the state itself
            r_busy      <= (w_state != S_IDLE) && (w_state != S_DONE);
            r_done      <= (w_state == S_DONE);
        end
    end

    assign o_instr_pt  = r_instr_pt;
    assign o_delay_num = r_delay_num;
    assign o_tx_data   = r_tx_data;
    assign o_tx_valid  = r_tx_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
endmodule

// File: tb/tb_glitch_sequencer.sv
// tb_glitch_sequencer: self-checking bench with a stub ROM and an instruction-level reference model.
module tb_glitch_sequencer;
    localparam int PL = 14;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        tx_ready = 1'b1;
    logic [7:0]  instr_pt, delay_num, tx_data;
    logic [11:0] instr;
    logic [31:0] delay_len;
    logic        tx_valid, glitch_out, busy, done, err;

    logic [11:0] rom [0:255];
    logic [31:0] dly [0:255];

    typedef struct packed {logic g; logic v; logic [7:0] d;} ev_t;
    ev_t        exp_q[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] got_bytes[$];
    logic       exp_err;

    int checks = 0;
    int failures = 0;

    assign instr     = rom[instr_pt];
    assign delay_len = dly[delay_num];

    always #5 clk = ~clk;

    glitch_sequencer #(.PROG_LEN(PL), .BIT_CYCLES(BC)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .o_instr_pt   (instr_pt),
        .i_instr      (instr),
        .o_delay_num  (delay_num),
        .i_delay_len  (delay_len),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_glitch_out (glitch_out),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    function automatic logic [11:0] mk(input logic [1:0] op, input logic [7:0] p);
        return {op, 1'b1, p, 1'b0};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) begin
            rom[i] = mk(2'b01, 8'hFF);
            dly[i] = 32'd0;
        end
    endtask

    // Walks the program instruction by instruction and lists, for every busy
    // cycle, what glitch_out / tx_valid / tx_data should show (tx_ready held 1).
    function automatic void model();
        int pt;
        int n;
        logic [11:0] w;
        logic [7:0] p;
        exp_q.delete();
        exp_bytes.delete();
        exp_err = 1'b0;
        pt = 0;
        while (1) begin
            exp_q.push_back('0);
            if (pt == PL) break;
            w = rom[pt];
            p = w[8:1];
            exp_q.push_back('0);
            if (w[9] !== 1'b1 || w[0] !== 1'b0) begin
                exp_err = 1'b1;
                break;
            end
            if (w[11:10] == 2'b00) begin
                exp_q.push_back({1'b0, 1'b1, p});
                exp_bytes.push_back(p);
            end else if (w[11:10] == 2'b10) begin
                n = (dly[p] == 32'd0) ? 1 : int'(dly[p]);
                repeat (1 + n) exp_q.push_back('0);
            end else if (w[11:10] == 2'b01) begin
                if (p == 8'hFF) break;
                for (int b = 7; b >= 0; b--) repeat (BC) exp_q.push_back({p[b], 1'b0, 8'h00});
            end else begin
                exp_err = 1'b1;
            end
            pt++;
        end
    endfunction

    task automatic run_prog(input bit rnd, input int tag);
        int idx;
        int cyc;
        int nbad;
        int bad_bytes;
        ev_t e;
        idx = 0;
        cyc = 0;
        nbad = 0;
        model();
        got_bytes.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 4000) begin
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid && tx_ready) got_bytes.push_back(tx_data);
            if (!rnd) begin
                e = (idx < exp_q.size()) ? exp_q[idx] : '0;
                checks++;
                if (!busy || idx >= exp_q.size() || glitch_out !== e.g || tx_valid !== e.v || (e.v && tx_data !== e.d)) begin
                    failures++;
                    if (nbad < 4) $display("FAIL trace prog=%0d cyc=%0d: got busy=%b glitch=%b valid=%b data=%h, need busy=1 glitch=%b valid=%b data=%h",
                                           tag, idx, busy, glitch_out, tx_valid, tx_data, e.g, e.v, e.d);
                    nbad++;
                end
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        tx_ready = 1'b1;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done prog=%0d: got done=%b after %0d cycles, need 1", tag, done, cyc);
        end
        if (!rnd) begin
            checks++;
            if (idx != exp_q.size()) begin
                failures++;
                $display("FAIL length prog=%0d: got %0d busy cycles, need %0d", tag, idx, exp_q.size());
            end
        end
        checks++;
        if (err !== exp_err) begin
            failures++;
            $display("FAIL err prog=%0d: got %b, need %b", tag, err, exp_err);
        end
        bad_bytes = (got_bytes.size() != exp_bytes.size()) ? 1 : 0;
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            if (got_bytes[i] !== exp_bytes[i]) bad_bytes++;
        checks++;
        if (bad_bytes != 0) begin
            failures++;
            $display("FAIL bytes prog=%0d: got %0d bytes, need %0d (%0d differences)", tag, got_bytes.size(), exp_bytes.size(), bad_bytes);
        end
        checks++;
        if ({busy, glitch_out, tx_valid} !== 3'b000) begin
            failures++;
            $display("FAIL idle_outputs prog=%0d: got busy/glitch/valid=%b, need 000", tag, {busy, glitch_out, tx_valid});
        end
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done: got done=%b, need 1", name, done);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({instr_pt, delay_num, tx_data} !== 24'h0) begin
            failures++;
            $display("FAIL reset_buses: got pt=%h dnum=%h data=%h, need 00", instr_pt, delay_num, tx_data);
        end
        checks++;
        if ({tx_valid, glitch_out, busy, done, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b, need 00000", {tx_valid, glitch_out, busy, done, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle: got busy/done=%b, need 00", {busy, done});
        end
    endtask

    task automatic test_default_program();
        logic [7:0] want [6];
        want = '{8'h84, 8'h01, 8'h0F, 8'hA4, 8'h20, 8'hAA};
        clear_rom();
        dly[0] = 32'd8;
        dly[1] = 32'd6;
        dly[2] = 32'd10;
        dly[3] = 32'd4;
        rom[0]  = mk(2'b00, 8'h84);
        rom[1]  = mk(2'b10, 8'd0);
        rom[2]  = mk(2'b00, 8'h01);
        rom[3]  = mk(2'b01, 8'hF2);
        rom[4]  = mk(2'b00, 8'h0F);
        rom[5]  = mk(2'b10, 8'd1);
        rom[6]  = mk(2'b00, 8'hA4);
        rom[7]  = mk(2'b01, 8'hF2);
        rom[8]  = mk(2'b10, 8'd2);
        rom[9]  = mk(2'b00, 8'h20);
        rom[10] = mk(2'b01, 8'hF2);
        rom[11] = mk(2'b10, 8'd3);
        rom[12] = mk(2'b00, 8'hAA);
        rom[13] = mk(2'b01, 8'hFF);
        run_prog(1'b0, 1);
        checks++;
        if (got_bytes.size() != 6) begin
            failures++;
            $display("FAIL default_count: got %0d bytes, need 6", got_bytes.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_bytes[i] !== want[i]) begin
                    failures++;
                    $display("FAIL default_byte%0d: got %h, need %h", i, got_bytes[i], want[i]);
                end
            end
        end
        checks++;
        if ({done, err} !== 2'b10) begin
            failures++;
            $display("FAIL default_status: got done/err=%b, need 10", {done, err});
        end
    endtask

    task automatic test_backpressure();
        int t;
        clear_rom();
        rom[0] = mk(2'b00, 8'h84);
        tx_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!tx_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t != 2) begin
            failures++;
            $display("FAIL bp_valid_rise: got valid after %0d cycles from fetch, need 2", t);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h84 || instr_pt !== 8'd0) begin
                failures++;
                $display("FAIL bp_hold%0d: got valid=%b data=%h pt=%0d, need 1/84/0", k, tx_valid, tx_data, instr_pt);
            end
            if (k == 5) tx_ready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (tx_valid !== 1'b0 || instr_pt !== 8'd1) begin
            failures++;
            $display("FAIL bp_accept: got valid=%b pt=%0d, need 0/1", tx_valid, instr_pt);
        end
        wait_done("bp");
    endtask

    task automatic test_delay_edges();
        clear_rom();
        dly[0] = 32'd0;
        dly[1] = 32'd1;
        dly[2] = 32'd3;
        rom[0] = mk(2'b10, 8'd0);
        rom[1] = mk(2'b10, 8'd1);
        rom[2] = mk(2'b10, 8'd2);
        run_prog(1'b0, 2);
    endtask

    task automatic test_pulse();
        logic [15:0] want;
        want = 16'hFF0C;
        clear_rom();
        rom[0] = mk(2'b01, 8'hF2);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (glitch_out !== want[15-i]) begin
                failures++;
                $display("FAIL pulse_bit%0d: got %b, need %b", i, glitch_out, want[15-i]);
            end
            @(negedge clk);
        end
        checks++;
        if (glitch_out !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pulse_exit: got glitch=%b busy=%b, need 0/1", glitch_out, busy);
        end
        wait_done("pulse");
        run_prog(1'b0, 3);
    endtask

    task automatic test_errors();
        clear_rom();
        rom[0] = 12'b00_0_00000001_0;
        rom[1] = mk(2'b00, 8'h11);
        run_prog(1'b0, 4);
        checks++;
        if (err !== 1'b1 || instr_pt !== 8'd0) begin
            failures++;
            $display("FAIL framing: got err=%b pt=%0d, need 1/0", err, instr_pt);
        end
        clear_rom();
        rom[0] = mk(2'b11, 8'h00);
        rom[1] = mk(2'b00, 8'h55);
        run_prog(1'b0, 5);
        checks++;
        if (err !== 1'b1 || instr_pt !== 8'd2) begin
            failures++;
            $display("FAIL reserved: got err=%b pt=%0d, need 1/2", err, instr_pt);
        end
        clear_rom();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: got %b, need 0", err);
        end
        wait_done("errclr");
    endtask

    task automatic test_abort_and_reset();
        int t;
        clear_rom();
        rom[0] = mk(2'b00, 8'h33);
        rom[1] = mk(2'b10, 8'd0);
        dly[0] = 32'd40;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({busy, done, tx_valid, glitch_out, err} !== 5'b0) begin
            failures++;
            $display("FAIL abort_idle: got busy/done/valid/glitch/err=%b, need 00000", {busy, done, tx_valid, glitch_out, err});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL abort_stays: got busy/done=%b, need 00", {busy, done});
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || instr_pt !== 8'd0) begin
            failures++;
            $display("FAIL abort_restart: got busy=%b pt=%0d, need 1/0", busy, instr_pt);
        end
        wait_done("abort");
        clear_rom();
        rom[0] = mk(2'b01, 8'hF2);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!glitch_out && t < 50) begin
            @(negedge clk);
            t++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({instr_pt, delay_num, tx_data, tx_valid, glitch_out, busy, done, err} !== 29'h0) begin
            failures++;
            $display("FAIL async_reset: got glitch=%b busy=%b pt=%0d, need all zero", glitch_out, busy, instr_pt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_prog(1'b0, 6);
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [7:0] p;
        for (int it = 0; it < 12; it++) begin
            clear_rom();
            for (int i = 0; i < 256; i++) dly[i] = 32'($urandom_range(0, 5));
            for (int i = 0; i < PL; i++) begin
                op = 2'($urandom_range(0, 3));
                p = 8'($urandom);
                if (op == 2'b01 && $urandom_range(0, 7) == 0) p = 8'hFF;
                rom[i] = mk(op, p);
                if ($urandom_range(0, 24) == 0) rom[i][0] = 1'b1;
            end
            run_prog(it % 3 == 2, 100 + it);
        end
    endtask

    initial begin
        test_reset();
        test_default_program();
        test_backpressure();
        test_delay_edges();
        test_pulse();
        test_errors();
        test_abort_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/glitch_sequencer.md
# glitch_sequencer

Executes the glitch program held in the combinational program ROM. It fetches 12-bit instructions by instruction pointer, decodes them and drives three things: framed byte sends on a valid/ready port, indexed delays looked up in the ROM's delay table, and bit-serial glitch pulse patterns. It sits between the top-level trigger/control logic and the ROM; the ROM is pure lookup and this block owns all sequencing.

## Interface
- PROG_LEN, 14: number of valid program entries; pointer reaching it ends the run.
- BIT_CYCLES, 1: clock cycles each pulse-pattern bit is held on `glitch_out` (≥1).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle run request; honoured only in IDLE or DONE.
- `abort` in 1: synchronous abort; returns to IDLE next cycle from any state.
- `instr_pt` out 8: ROM instruction address.
- `instr` in 12: ROM instruction, combinational from `instr_pt`.
- `delay_num` out 8: ROM delay-table index.
- `delay_len` in 32: ROM delay length in cycles, combinational from `delay_num`.
- `tx_data` out 8: byte to send.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: downstream accepts the byte when high with `tx_valid`.
- `glitch_out` out 1: glitch drive.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high in DONE.
- `err` out 1: sticky error flag; cleared by `start`.

## Operation
- Instruction fields: [11:10] opcode, [9] start bit (must be 1), [8:1] payload, [0] stop bit (must be 0).
- States: IDLE, FETCH, DECODE, SEND, DLY_LOAD, DLY_RUN, PULSE, DONE.
- IDLE/DONE + `start`: `instr_pt` ← 0, `err` ← 0, go to FETCH.
- FETCH: if `instr_pt` == PROG_LEN, go to DONE. Otherwise register `instr` into `ir` and go to DECODE.
- DECODE, bad framing (`ir[9]`≠1 or `ir[0]`≠0): set `err`, go to DONE.
- DECODE, op 00 SEND: `tx_data` ← payload, go to SEND.
- DECODE, op 10 DELAY: `delay_num` ← payload, go to DLY_LOAD.
- DECODE, op 01 PULSE: payload 8'hFF means HALT and goes to DONE. Any other payload loads the pattern shifter, go to PULSE.
- DECODE, op 11: reserved; set `err`, treat as NOP (advance pointer, go to FETCH).
- SEND: hold `tx_valid` high and `tx_data` stable until `tx_ready` is sampled high. Then advance and go to FETCH.
- DLY_LOAD: counter ← `delay_len`, go to DLY_RUN.
- DLY_RUN: decrement each cycle. Leave after max(N,1) cycles, so N = 0 behaves like N = 1. Then advance and go to FETCH.
- PULSE: shift the pattern MSB first onto `glitch_out`, each bit held BIT_CYCLES cycles, 8 bits total. `glitch_out` returns to 0 on exit. Then advance and go to FETCH.
- Advance: `instr_pt` ← `instr_pt` + 1, 8-bit. There is no wrap hazard because PROG_LEN ≤ 255 is checked first.
- `abort` has priority over every transition. It forces IDLE and zeros `tx_valid`, `glitch_out` and the counters. It does not set `err`.
- `start` outside IDLE/DONE is ignored.

## Timing
- Reset values: `instr_pt`=0, `delay_num`=0, `tx_data`=0, `tx_valid`=0, `glitch_out`=0, `busy`=0, `done`=0, `err`=0. State is IDLE.
- All outputs are registered. The ROM is read combinationally within a cycle.
- Fixed per-instruction overhead: FETCH + DECODE = 2 cycles.
- SEND: 1 + wait cycles. `tx_valid` rises the cycle after DECODE.
- DELAY: DLY_LOAD (1) + max(N,1) cycles in DLY_RUN.
- PULSE: exactly 8×BIT_CYCLES cycles. The first bit appears the cycle after DECODE.
- HALT or end of program: `done` rises 1 cycle after DECODE or FETCH respectively.
- `abort` together with `tx_ready` in SEND: the abort wins and the byte counts as not sent by this block.
- Reset asserted mid-run: all outputs go to reset values immediately (asynchronously).

## Structure
- Shared package `glitch_pkg`:
  - opcode constants `OP_SEND`=2'b00, `OP_PULSE`=2'b01, `OP_DELAY`=2'b10, `OP_RSVD`=2'b11;
  - `HALT_PAYLOAD`=8'hFF;
  - the state enum;
  - field position constants.
- One sub-module, `pulse_shifter`: 8-bit parallel-load shifter with BIT_CYCLES prescaler, a `load`/`active` handshake and `bit_out`.

## Test plan
- Full default program with `tx_ready` tied 1: bytes 84,01,0F,A4,20,AA appear in order. Delays of 8000, 602,999, 108,000 and 67,300,000 cycles occur (last shortened in sim via a stub ROM). Pattern F2 pulses 3×, then HALT; `done`=1, `err`=0.
- SEND backpressure: `tx_ready` low 5 cycles → `tx_valid` high and `tx_data`=84 stable for 6 cycles. The pointer advances only after acceptance.
- Stub ROM `delay_len`=0 and =1: DLY_RUN lasts 1 cycle in both cases. With `delay_len`=3 it lasts 3 cycles.
- PULSE F2 with BIT_CYCLES=2: `glitch_out` = 1,1,1,1,0,0,1,0, each bit held 2 cycles (16 cycles). It is 0 afterwards.
- Bad framing (instr 12'b00_0_00000001_0), then op 11 in a second program: both set `err`. The first goes to DONE; the second advances. A later `start` clears `err`.
- `abort` mid-DLY_RUN, and `rst_n` low mid-PULSE: the block returns to IDLE / reset values with `glitch_out`=0. A following `start` restarts at `instr_pt`=0.
